// File: rtl/fetch_stage_ctrl_if.sv
// fetch_stage_ctrl_if: hazard/redirect handshake and IF_ID view between later stages and fetch.
interface fetch_stage_ctrl_if #(
  parameter int PC_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic PC_Write;
  logic if_id_Write;
  logic flush;
  logic [PC_WIDTH-1:0] target_pc;
  logic [INST_WIDTH-1:0] imem_inst;
  logic [PC_WIDTH-1:0] pc;
  logic [INST_WIDTH-1:0] if_id_inst;
  logic [PC_WIDTH-1:0] if_id_pc;
  logic if_id_valid;
  logic [1:0] state;
  logic [7:0] stall_streak;
  logic stall_timeout;
  logic [31:0] stall_total;
  logic [31:0] flush_total;
  modport master (
    output PC_Write, if_id_Write, flush, target_pc, imem_inst,
    input pc, if_id_inst, if_id_pc, if_id_valid, state, stall_streak, stall_timeout, stall_total, flush_total
  );
  modport slave (
    input PC_Write, if_id_Write, flush, target_pc, imem_inst,
    output pc, if_id_inst, if_id_pc, if_id_valid, state, stall_streak, stall_timeout, stall_total, flush_total
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC register and IF_ID buffer applying hold/flush, with stall streak tracking.
// Optional STALL_PERF_COUNTER_EN adds free-running stall/flush cycle totals.
module fetch_stage_ctrl #(
  parameter int PC_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_INC = 1,
  parameter logic [INST_WIDTH-1:0] NOP_INST = '0,
  parameter int MAX_STALL = 15
) (
  input logic clk,
  input logic rst,
  fetch_stage_ctrl_if.slave bus
);
  typedef enum logic [1:0] {FILL, RUN, STALL, FLUSHED} state_t;
  localparam logic [7:0] MAX = 8'(MAX_STALL);
  state_t cur, nxt;
  logic stall;
  logic [PC_WIDTH-1:0] pc_r, ipc_r;
  logic [INST_WIDTH-1:0] inst_r;
  logic valid_r, to_r;
  logic [7:0] streak_r;
  assign stall = !bus.flush && !bus.PC_Write;
  always_ff @(posedge clk) cur <= rst ? FILL : nxt;
  always_comb begin
    nxt = RUN;
    nxt = bus.flush ? FLUSHED : (stall ? STALL : RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
      inst_r <= NOP_INST;
      ipc_r <= '0;
      valid_r <= 1'b0;
    end else if (bus.flush) begin
      pc_r <= bus.target_pc;
      inst_r <= NOP_INST;
      ipc_r <= '0;
      valid_r <= 1'b0;
    end else begin
      if (bus.PC_Write) pc_r <= pc_r + PC_WIDTH'(PC_INC);
      if (bus.if_id_Write) begin
        inst_r <= bus.imem_inst;
        ipc_r <= pc_r;
        valid_r <= 1'b1;
      end
    end
  end
  // timeout latches on the stall that brings the streak up to the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_r <= '0;
      to_r <= 1'b0;
    end else begin
      streak_r <= !stall ? 8'd0 : (streak_r >= MAX ? MAX : streak_r + 8'd1);
      if (stall && streak_r >= MAX - 8'd1) to_r <= 1'b1;
    end
  end
`ifdef STALL_PERF_COUNTER_EN
  logic [31:0] st_cnt, fl_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (stall) st_cnt <= st_cnt + 32'd1;
      if (bus.flush) fl_cnt <= fl_cnt + 32'd1;
    end
  end
  assign bus.stall_total = st_cnt;
  assign bus.flush_total = fl_cnt;
`else
  assign bus.stall_total = '0;
  assign bus.flush_total = '0;
`endif
  assign bus.pc = pc_r;
  assign bus.if_id_inst = inst_r;
  assign bus.if_id_pc = ipc_r;
  assign bus.if_id_valid = valid_r;
  assign bus.state = cur;
  assign bus.stall_streak = streak_r;
  assign bus.stall_timeout = to_r;
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl: table-driven vectors with a scoreboard queue for fetch_stage_ctrl.
module tb_fetch_stage_ctrl;
  logic clk = 0;
  logic rst;
  int errors = 0;
  int checks = 0;
  int st_model = 0;
  int fl_model = 0;
  typedef struct {
    logic r, pcw, ifw, fl;
    logic [31:0] tgt, pc, inst, ipc;
    logic v;
    logic [1:0] st;
    logic [7:0] sk;
    logic to;
  } vec_t;
  vec_t tbl[18];
  vec_t sb[$];
  fetch_stage_ctrl_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();
  fetch_stage_ctrl #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'd0), .PC_INC(1), .NOP_INST(32'd0), .MAX_STALL(15)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  assign bus.imem_inst = bus.pc + 32'h100;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.r;
    bus.PC_Write = v.pcw;
    bus.if_id_Write = v.ifw;
    bus.flush = v.fl;
    bus.target_pc = v.tgt;
    sb.push_back(v);
    if (v.r) begin
      st_model = 0;
      fl_model = 0;
    end else if (v.fl) fl_model++;
    else if (!v.pcw) st_model++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc", bus.pc, e.pc);
    chk("if_id_inst", bus.if_id_inst, e.inst);
    chk("if_id_pc", bus.if_id_pc, e.ipc);
    chk("if_id_valid", 32'(bus.if_id_valid), 32'(e.v));
    chk("state", 32'(bus.state), 32'(e.st));
    chk("stall_streak", 32'(bus.stall_streak), 32'(e.sk));
    chk("stall_timeout", 32'(bus.stall_timeout), 32'(e.to));
`ifdef STALL_PERF_COUNTER_EN
    chk("stall_total", bus.stall_total, 32'(st_model));
    chk("flush_total", bus.flush_total, 32'(fl_model));
`else
    chk("stall_total", bus.stall_total, 32'd0);
    chk("flush_total", bus.flush_total, 32'd0);
`endif
  endtask
  initial begin
    rst = 1;
    bus.PC_Write = 0;
    bus.if_id_Write = 0;
    bus.flush = 0;
    bus.target_pc = '0;
    //          r  pcw ifw fl  tgt    pc     inst   ipc    v  st sk to
    tbl[0]  = '{1, 1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 32'h0, 32'h1, 32'h100, 32'h0, 1, 1, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 32'h0, 32'h2, 32'h101, 32'h1, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, 32'h0, 32'h3, 32'h102, 32'h2, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 32'h0, 32'h4, 32'h103, 32'h3, 1, 1, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 32'h0, 32'h5, 32'h104, 32'h4, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 32'h0, 32'h5, 32'h104, 32'h4, 1, 2, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 32'h0, 32'h5, 32'h104, 32'h4, 1, 2, 2, 0};
    tbl[8]  = '{0, 1, 1, 0, 32'h0, 32'h6, 32'h105, 32'h5, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 32'h0, 32'h6, 32'h106, 32'h6, 1, 2, 1, 0};
    tbl[10] = '{0, 1, 0, 0, 32'h0, 32'h7, 32'h106, 32'h6, 1, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 32'h40, 32'h40, 32'h0, 32'h0, 0, 3, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 32'h0, 32'h41, 32'h140, 32'h40, 1, 1, 0, 0};
    tbl[13] = '{0, 1, 1, 1, 32'h80, 32'h80, 32'h0, 32'h0, 0, 3, 0, 0};
    tbl[14] = '{0, 0, 1, 1, 32'h80, 32'h80, 32'h0, 32'h0, 0, 3, 0, 0};
    tbl[15] = '{0, 1, 1, 0, 32'h0, 32'h81, 32'h180, 32'h80, 1, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 32'h0, 32'h81, 32'h180, 32'h80, 1, 2, 1, 0};
    tbl[17] = '{0, 0, 0, 1, 32'h10, 32'h10, 32'h0, 32'h0, 0, 3, 0, 0};
    for (int i = 0; i < 18; i++) step(tbl[i]);
    // long stall: streak saturates, timeout sticks until reset
    step('{1, 1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0});
    for (int i = 1; i <= 20; i++)
      step('{0, 0, 1, 0, 32'h0, 32'h0, 32'h100, 32'h0, 1, 2, 8'(i > 15 ? 15 : i), i >= 15});
    step('{0, 1, 1, 0, 32'h0, 32'h1, 32'h100, 32'h0, 1, 1, 0, 1});
    step('{0, 0, 0, 0, 32'h0, 32'h1, 32'h100, 32'h0, 1, 2, 1, 1});
    step('{0, 0, 0, 0, 32'h0, 32'h1, 32'h100, 32'h0, 1, 2, 2, 1});
    step('{1, 0, 0, 1, 32'h55, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0});
    // wrap of the all-ones PC
    step('{0, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 3, 0, 0});
    step('{0, 1, 1, 0, 32'h0, 32'h0, 32'hFF, 32'hFFFFFFFF, 1, 1, 0, 0});
    step('{0, 1, 1, 0, 32'h0, 32'h1, 32'h100, 32'h0, 1, 1, 0, 0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
